complex_fir_stream: RTL and testbench

COMPLEX_FIR_STREAM -- requirements
Module: complex_fir_stream

---
 rtl/complex_fir_stream.sv | 198 +++++++++++++++++++
 tb/tb_complex_fir_stream.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/complex_fir_stream.sv
// Complex-valued streaming FIR filter.
// Each accepted sample is run through NTAPS sequential complex MAC cycles
// against the coefficient bank. The result is then held on the output stream
// until it is consumed. A sample marked last arms NTAPS-1 internal zero samples
// that flush the filter tail. The delay line is cleared after the final flush
// output, so packets do not interact.
module complex_fir_stream #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 8,
  parameter int NTAPS  = 11,
  parameter int ACC_W  = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  // sample input stream
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic signed [DATA_W-1:0]   in_re,
  input  logic signed [DATA_W-1:0]   in_im,
  input  logic                       in_last,
  // result output stream
  input  logic                       out_ready,
  output logic                       out_valid,
  output logic signed [ACC_W-1:0]    out_re,
  output logic signed [ACC_W-1:0]    out_im,
  output logic                       out_last,
  // coefficient write port
  input  logic                       coef_we,
  input  logic [$clog2(NTAPS)-1:0]   coef_addr,
  input  logic signed [COEF_W-1:0]   coef_re,
  input  logic signed [COEF_W-1:0]   coef_im,
  output logic                       busy
);

  localparam int AW = $clog2(NTAPS);
  // single real product width, and width of a sum/difference of two products
  localparam int MW = DATA_W + COEF_W;
  localparam int PW = MW + 1;

  localparam logic [AW:0] NT = (AW+1)'(NTAPS);
  localparam logic [AW:0] FL = (AW+1)'(NTAPS - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_MAC   = 2'd1;
  localparam logic [1:0] S_OUT   = 2'd2;
  localparam logic [1:0] S_FLUSH = 2'd3;

  logic [1:0]               r_state;
  logic signed [DATA_W-1:0] r_x_re [NTAPS];
  logic signed [DATA_W-1:0] r_x_im [NTAPS];
  logic signed [COEF_W-1:0] r_c_re [NTAPS];
  logic signed [COEF_W-1:0] r_c_im [NTAPS];
  logic signed [ACC_W-1:0]  r_acc_re;
  logic signed [ACC_W-1:0]  r_acc_im;
  logic signed [ACC_W-1:0]  r_p_re;
  logic signed [ACC_W-1:0]  r_p_im;
  logic [AW:0]              r_k;
  logic [AW:0]              r_flush_rem;
  logic                     r_flush_arm;

  logic                     w_accept;
  logic                     w_cw_ok;
  logic                     w_final;
  logic                     w_consume;
  logic [AW-1:0]            w_sel;
  logic signed [MW-1:0]     w_pp_rr;
  logic signed [MW-1:0]     w_pp_ii;
  logic signed [MW-1:0]     w_pp_ri;
  logic signed [MW-1:0]     w_pp_ir;
  logic signed [PW-1:0]     w_mac_re;
  logic signed [PW-1:0]     w_mac_im;
  logic signed [ACC_W-1:0]  w_ext_re;
  logic signed [ACC_W-1:0]  w_ext_im;

  assign in_ready  = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign out_valid = (r_state == S_OUT);
  assign out_re    = r_acc_re;
  assign out_im    = r_acc_im;
  assign w_final   = r_flush_arm && (r_flush_rem == '0);
  assign out_last  = (r_state == S_OUT) && w_final;
  assign w_accept  = in_valid && (r_state == S_IDLE);
  assign w_consume = (r_state == S_OUT) && out_ready;
  assign w_cw_ok   = coef_we && (r_state == S_IDLE) && ({1'b0, coef_addr} < NT);

  // Tap select and full-precision complex product of the current tap
  always_comb begin
    w_sel    = (r_k < NT) ? r_k[AW-1:0] : '0;
    w_pp_rr  = MW'(r_x_re[w_sel]) * MW'(r_c_re[w_sel]);
    w_pp_ii  = MW'(r_x_im[w_sel]) * MW'(r_c_im[w_sel]);
    w_pp_ri  = MW'(r_x_re[w_sel]) * MW'(r_c_im[w_sel]);
    w_pp_ir  = MW'(r_x_im[w_sel]) * MW'(r_c_re[w_sel]);
    w_mac_re = PW'(w_pp_rr) - PW'(w_pp_ii);
    w_mac_im = PW'(w_pp_ri) + PW'(w_pp_ir);
    w_ext_re = ACC_W'(w_mac_re);
    w_ext_im = ACC_W'(w_mac_im);
  end

  // Coefficient bank: identity after reset, writable only while idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NTAPS; i++) begin
        r_c_re[i] <= '0;
        r_c_im[i] <= '0;
      end
      r_c_re[0] <= COEF_W'(1);
    end else if (w_cw_ok) begin
      r_c_re[coef_addr] <= coef_re;
      r_c_im[coef_addr] <= coef_im;
    end
  end

  // Delay line: shift on a real or flush sample, clear when the packet ends
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NTAPS; i++) begin
        r_x_re[i] <= '0;
        r_x_im[i] <= '0;
      end
    end else if (w_accept || (r_state == S_FLUSH)) begin
      for (int unsigned i = 1; i < NTAPS; i++) begin
        r_x_re[i] <= r_x_re[i-1];
        r_x_im[i] <= r_x_im[i-1];
      end
      r_x_re[0] <= w_accept ? in_re : '0;
      r_x_im[0] <= w_accept ? in_im : '0;
    end else if (w_consume && w_final) begin
      for (int unsigned i = 0; i < NTAPS; i++) begin
        r_x_re[i] <= '0;
        r_x_im[i] <= '0;
      end
    end
  end

  // Sequencer. The product is registered before it is accumulated, so MAC
  // runs one extra drain cycle (k == NTAPS). That cycle places out_valid
  // NTAPS+1 cycles after the accept edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_acc_re    <= '0;
      r_acc_im    <= '0;
      r_p_re      <= '0;
      r_p_im      <= '0;
      r_k         <= '0;
      r_flush_rem <= '0;
      r_flush_arm <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_acc_re <= '0;
            r_acc_im <= '0;
            r_k      <= '0;
            r_state  <= S_MAC;
            if (in_last) begin
              r_flush_arm <= 1'b1;
              r_flush_rem <= FL;
            end
          end
        end
        S_MAC: begin
          if (r_k < NT) begin
            r_p_re <= w_ext_re;
            r_p_im <= w_ext_im;
            r_k    <= r_k + (AW+1)'(1);
          end
          if (r_k != '0) begin
            r_acc_re <= r_acc_re + r_p_re;
            r_acc_im <= r_acc_im + r_p_im;
          end
          if (r_k == NT) begin
            r_state <= S_OUT;
          end
        end
        S_OUT: begin
          if (out_ready) begin
            if (r_flush_arm && (r_flush_rem != '0)) begin
              r_state <= S_FLUSH;
            end else begin
              r_flush_arm <= 1'b0;
              r_state     <= S_IDLE;
            end
          end
        end
        default: begin
          // S_FLUSH: internal zero sample, otherwise identical to an accept
          r_acc_re    <= '0;
          r_acc_im    <= '0;
          r_k         <= '0;
          r_flush_rem <= r_flush_rem - (AW+1)'(1);
          r_state     <= S_MAC;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_complex_fir_stream.sv
// Self-checking bench for complex_fir_stream: directed steps plus randomized
// packets, compared against a packet-level complex convolution model.
module tb_complex_fir_stream;

  localparam int DATA_W = 16;
  localparam int COEF_W = 8;
  localparam int NTAPS  = 11;
  localparam int ACC_W  = 32;
  localparam int AW     = $clog2(NTAPS);

  logic                     clk;
  logic                     rst_n;
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_re;
  logic signed [DATA_W-1:0] in_im;
  logic                     in_last;
  logic                     out_ready;
  logic                     out_valid;
  logic signed [ACC_W-1:0]  out_re;
  logic signed [ACC_W-1:0]  out_im;
  logic                     out_last;
  logic                     coef_we;
  logic [AW-1:0]            coef_addr;
  logic signed [COEF_W-1:0] coef_re;
  logic signed [COEF_W-1:0] coef_im;
  logic                     busy;

  complex_fir_stream #(
    .DATA_W(DATA_W),
    .COEF_W(COEF_W),
    .NTAPS (NTAPS),
    .ACC_W (ACC_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_re    (in_re),
    .in_im    (in_im),
    .in_last  (in_last),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .out_re   (out_re),
    .out_im   (out_im),
    .out_last (out_last),
    .coef_we  (coef_we),
    .coef_addr(coef_addr),
    .coef_re  (coef_re),
    .coef_im  (coef_im),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass   = 0;
  int n_checks = 0;

  // reference state: coefficient bank and current packet
  int m_cre [NTAPS];
  int m_cim [NTAPS];
  int px_re [$];
  int px_im [$];

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  function automatic longint wrap(input longint v);
    logic signed [ACC_W-1:0] t;
    t = v[ACC_W-1:0];
    return longint'(t);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NTAPS; i++) begin
      m_cre[i] = 0;
      m_cim[i] = 0;
    end
    m_cre[0] = 1;
  endtask

  // write issued while idle; model follows only for in-range addresses
  task automatic coef_write(input int a, input int re, input int im);
    coef_we   = 1'b1;
    coef_addr = AW'(a);
    coef_re   = COEF_W'(re);
    coef_im   = COEF_W'(im);
    @(posedge clk);
    @(negedge clk);
    coef_we = 1'b0;
    if (a < NTAPS) begin
      m_cre[a] = re;
      m_cim[a] = im;
    end
  endtask

  task automatic send_sample(input int re, input int im, input bit last,
                             input bit cw, input int ca, input int cre, input int cim);
    int w;
    w = 0;
    while (!in_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) chk("in_ready_wait", in_ready, 1);
    in_valid  = 1'b1;
    in_re     = DATA_W'(re);
    in_im     = DATA_W'(im);
    in_last   = last;
    coef_we   = cw;
    coef_addr = AW'(ca);
    coef_re   = COEF_W'(cre);
    coef_im   = COEF_W'(cim);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    coef_we  = 1'b0;
    in_re    = DATA_W'($urandom);
    in_im    = DATA_W'($urandom);
    in_last  = 1'($urandom);
    chk("accept_busy", busy, 1);
    chk("accept_in_ready", in_ready, 0);
  endtask

  task automatic recv(input string tag, input longint er, input longint ei,
                      input bit el, input int stall, input bit chk_lat);
    int w;
    w = 0;
    while (!out_valid && w < 200) begin
      @(negedge clk);
      w++;
    end
    chk($sformatf("%s_valid", tag), out_valid, 1);
    if (!out_valid) return;
    if (chk_lat) chk($sformatf("%s_lat", tag), w, NTAPS + 1);
    chk($sformatf("%s_re", tag), $signed(out_re), er);
    chk($sformatf("%s_im", tag), $signed(out_im), ei);
    chk($sformatf("%s_last", tag), out_last, el);
    chk($sformatf("%s_inrdy", tag), in_ready, 0);
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      chk($sformatf("%s_hold_v", tag), out_valid, 1);
      chk($sformatf("%s_hold_re", tag), $signed(out_re), er);
      chk($sformatf("%s_hold_im", tag), $signed(out_im), ei);
      chk($sformatf("%s_hold_last", tag), out_last, el);
      chk($sformatf("%s_hold_inrdy", tag), in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk($sformatf("%s_drop", tag), out_valid, 0);
    if (el) begin
      chk($sformatf("%s_idle_rdy", tag), in_ready, 1);
      chk($sformatf("%s_idle_busy", tag), busy, 0);
    end
  endtask

  // stall_mode: 0 none, 1 random 0..2 cycles, 2 five cycles on first output
  task automatic run_packet(input string name, input int stall_mode,
                            input bit same_cw, input int ca, input int cre, input int cim,
                            input bit mac_cw);
    int n, oi, cnt, st;
    longint s_re, s_im;
    longint er [$];
    longint ei [$];
    n = px_re.size();
    if (same_cw && ca < NTAPS) begin
      m_cre[ca] = cre;
      m_cim[ca] = cim;
    end
    // y[m] = sum_k c[k] * x[m-k] over the packet followed by zeros
    for (int m = 0; m < n + NTAPS - 1; m++) begin
      s_re = 0;
      s_im = 0;
      for (int k = 0; k < NTAPS; k++) begin
        if (m - k >= 0 && m - k < n) begin
          s_re += longint'(px_re[m-k]) * m_cre[k] - longint'(px_im[m-k]) * m_cim[k];
          s_im += longint'(px_re[m-k]) * m_cim[k] + longint'(px_im[m-k]) * m_cre[k];
        end
      end
      er.push_back(wrap(s_re));
      ei.push_back(wrap(s_im));
    end
    oi = 0;
    for (int j = 0; j < n; j++) begin
      send_sample(px_re[j], px_im[j], (j == n - 1), same_cw && (j == 0), ca, cre, cim);
      if (mac_cw && j == 0) begin
        repeat (3) @(negedge clk);
        coef_we   = 1'b1;
        coef_addr = '0;
        coef_re   = COEF_W'(99);
        coef_im   = COEF_W'(-77);
        @(posedge clk);
        @(negedge clk);
        coef_we = 1'b0;
      end
      cnt = (j == n - 1) ? NTAPS : 1;
      for (int q = 0; q < cnt; q++) begin
        if (stall_mode == 2 && oi == 0) st = 5;
        else if (stall_mode == 1) st = int'($urandom_range(0, 2));
        else st = 0;
        recv($sformatf("%s_o%0d", name, oi), er[oi], ei[oi], (oi == n + NTAPS - 2),
             st, (q == 0) && !(mac_cw && j == 0));
        oi++;
      end
    end
  endtask

  task automatic load_impulse_coefs();
    int vals [NTAPS] = '{1, 0, 2, 0, 3, 4, 3, 0, 2, 0, 1};
    for (int i = 0; i < NTAPS; i++) coef_write(i, vals[i], 0);
  endtask

  task automatic set_packet1(input int re, input int im);
    px_re = {};
    px_im = {};
    px_re.push_back(re);
    px_im.push_back(im);
  endtask

  int seen;
  int len;

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_re     = '0;
    in_im     = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    coef_we   = 1'b0;
    coef_addr = '0;
    coef_re   = '0;
    coef_im   = '0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_re", $signed(out_re), 0);
    chk("rst_out_im", $signed(out_im), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // identity coefficients after reset: 5-3i then ten zeros
    set_packet1(5, -3);
    run_packet("ident", 0, 1'b0, 0, 0, 0, 1'b0);

    // impulse readback; out-of-range writes must not land anywhere
    load_impulse_coefs();
    for (int a = NTAPS; a < (1 << AW); a++) coef_write(a, 55, -55);
    set_packet1(1, 0);
    run_packet("imp", 0, 1'b0, 0, 0, 0, 1'b0);

    // purely imaginary coefficient: (3+4i)*i = -4+3i
    coef_write(0, 0, 1);
    for (int i = 1; i < NTAPS; i++) coef_write(i, 0, 0);
    set_packet1(3, 4);
    run_packet("cplx", 0, 1'b0, 0, 0, 0, 1'b0);

    // backpressure on a multi-sample packet
    load_impulse_coefs();
    px_re = {};
    px_im = {};
    for (int i = 0; i < 3; i++) begin
      px_re.push_back(int'($urandom_range(0, 65535)) - 32768);
      px_im.push_back(int'($urandom_range(0, 65535)) - 32768);
    end
    run_packet("bp", 2, 1'b0, 0, 0, 0, 1'b0);

    // write attempted during MAC is dropped, then impulse readback
    set_packet1(1234, -567);
    run_packet("maccw", 0, 1'b0, 0, 0, 0, 1'b1);
    set_packet1(1, 0);
    run_packet("imp2", 0, 1'b0, 0, 0, 0, 1'b0);

    // coefficient write on the accept edge is used by that sample
    px_re = {};
    px_im = {};
    px_re.push_back(700);
    px_im.push_back(-300);
    px_re.push_back(-25);
    px_im.push_back(900);
    run_packet("samecw", 0, 1'b1, 0, -5, 2, 1'b0);

    // randomized coefficients, packet lengths, data and stalls
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < NTAPS; i++)
        coef_write(i, int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128);
      len = int'($urandom_range(1, 5));
      px_re = {};
      px_im = {};
      for (int i = 0; i < len; i++) begin
        px_re.push_back(int'($urandom_range(0, 65535)) - 32768);
        px_im.push_back(int'($urandom_range(0, 65535)) - 32768);
      end
      run_packet($sformatf("rnd%0d", p), 1, 1'b0, 0, 0, 0, 1'b0);
    end

    // reset mid-MAC abandons the sample and restores identity
    send_sample(321, 123, 1'b1, 1'b0, 0, 0, 0);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mrst_out_valid", out_valid, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_in_ready", in_ready, 1);
    chk("mrst_out_re", $signed(out_re), 0);
    chk("mrst_out_last", out_last, 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    chk("mrst_no_output", seen, 0);
    set_packet1(-4000, 2500);
    run_packet("postrst", 1, 1'b0, 0, 0, 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
